// File: rtl/mem_port_arbiter.sv
// N-channel arbiter that multiplexes CPU-side memory requesters onto one memory port.
// Round-robin or fixed-priority grant; each transaction is latched at grant.
module mem_port_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0]                req_read,
    input  logic [NUM_CH-1:0]                req_write,
    input  logic [NUM_CH*ADDR_W-1:0]         req_address,
    input  logic [NUM_CH*DATA_W-1:0]         req_wdata,
    input  logic [NUM_CH*(DATA_W/8)-1:0]     req_byte_enable,
    output logic [NUM_CH-1:0]                req_resp,
    output logic [DATA_W-1:0]                req_rdata,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [(DATA_W/8)-1:0]            mem_byte_enable,
    output logic [ADDR_W-1:0]                mem_address,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic                             mem_resp,
    input  logic [DATA_W-1:0]                mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  grant;
    logic [PTR_W-1:0]  sel;
    logic              sel_valid;
    logic [PTR_W:0]    cand;
    logic [NUM_CH-1:0] active;

    assign active = req_read | req_write;

    // Candidate index wraps by subtraction so NUM_CH need not be a power of two.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ARB_MODE == 1)
                cand = (PTR_W+1)'(i);
            else
                cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_CH))
                cand = cand - (PTR_W+1)'(NUM_CH);
            if (!sel_valid && active[cand[PTR_W-1:0]]) begin
                sel       = cand[PTR_W-1:0];
                sel_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            grant           <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            req_resp        <= '0;
            req_rdata       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_resp <= '0;
                    if (sel_valid) begin
                        grant           <= sel;
                        mem_address     <= req_address[sel*ADDR_W +: ADDR_W];
                        mem_wdata       <= req_wdata[sel*DATA_W +: DATA_W];
                        mem_byte_enable <= req_byte_enable[sel*BE_W +: BE_W];
                        // Read wins when both ops are set on the granted channel.
                        mem_read        <= req_read[sel];
                        mem_write       <= ~req_read[sel];
                        state           <= BUSY;
                        if (ARB_MODE == 0)
                            rr_ptr <= (sel == PTR_W'(NUM_CH-1)) ? '0 : sel + PTR_W'(1);
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        if (mem_read)
                            req_rdata <= mem_rdata;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        req_resp  <= NUM_CH'(1) << grant;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    req_resp <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a 4-channel round-robin instance under
// directed and random batches, plus a 2-channel fixed-priority instance.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_read = '0, req_write = '0;
    logic [N*AW-1:0] req_address = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N*BW-1:0] req_byte_enable = '0;
    logic [N-1:0]    req_resp;
    logic [DW-1:0]   req_rdata;
    logic            mem_read, mem_write;
    logic [BW-1:0]   mem_byte_enable;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_wdata;
    logic            mem_resp = 1'b0;
    logic [DW-1:0]   mem_rdata = '0;

    mem_port_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write), .req_address(req_address),
        .req_wdata(req_wdata), .req_byte_enable(req_byte_enable),
        .req_resp(req_resp), .req_rdata(req_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    logic [1:0]    fp_req_read = '0, fp_req_write = '0;
    logic [2*AW-1:0] fp_req_address = {32'h0000_2000, 32'h0000_1000};
    logic [2*DW-1:0] fp_req_wdata = '0;
    logic [2*BW-1:0] fp_req_byte_enable = '1;
    logic [1:0]    fp_req_resp;
    logic [DW-1:0] fp_req_rdata;
    logic          fp_mem_read, fp_mem_write;
    logic [BW-1:0] fp_mem_byte_enable;
    logic [AW-1:0] fp_mem_address;
    logic [DW-1:0] fp_mem_wdata;
    logic          fp_mem_resp = 1'b0;
    logic [DW-1:0] fp_mem_rdata = 32'hA5A5_0000;

    mem_port_arbiter #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst(rst),
        .req_read(fp_req_read), .req_write(fp_req_write), .req_address(fp_req_address),
        .req_wdata(fp_req_wdata), .req_byte_enable(fp_req_byte_enable),
        .req_resp(fp_req_resp), .req_rdata(fp_req_rdata),
        .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_byte_enable(fp_mem_byte_enable),
        .mem_address(fp_mem_address), .mem_wdata(fp_mem_wdata),
        .mem_resp(fp_mem_resp), .mem_rdata(fp_mem_rdata)
    );

    typedef struct {
        int            ch;
        bit            is_rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t exp_mem[$];
    txn_t exp_resp[$];
    int checks = 0;
    int errors = 0;

    int            model_ptr = 0;
    logic [DW-1:0] model_rdata = '0;
    logic [AW-1:0] ch_addr  [N];
    logic [DW-1:0] ch_wdata [N];
    logic [BW-1:0] ch_be    [N];
    int            force_lat = 0;
    bit            force_spur = 1'b0;

    function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
        if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
        return a * 32'h9E37_79B1 + 32'h1;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory side: checks each granted access, answers after a chosen latency,
    // and throws spurious mem_resp pulses whenever no strobe is up.
    txn_t         cur;
    logic [69:0]  cur_sig;
    int           hi_cnt = 0, lat = 1;
    bit           in_txn = 1'b0, resp_prev = 1'b0;
    logic         strobe;

    always @(negedge clk) begin
        if (rst) begin
            in_txn    = 1'b0;
            resp_prev = 1'b0;
            mem_resp  = 1'b0;
        end else begin
            strobe = mem_read | mem_write;
            if (resp_prev) begin
                chk("strobe_drop_after_resp", 128'(strobe), 128'(0));
                chk("resp_after_mem_resp", 128'(req_resp), 128'(N'(1) << cur.ch));
                resp_prev = 1'b0;
            end
            if (in_txn) begin
                chk("strobe_held", 128'(strobe), 128'(1));
                if (strobe) begin
                    hi_cnt++;
                    chk("mem_stable", 128'({mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable}),
                        128'(cur_sig));
                end else begin
                    in_txn = 1'b0;
                end
            end else if (strobe) begin
                if (exp_mem.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_access: actual addr=%0h required none", mem_address);
                end else begin
                    cur = exp_mem.pop_front();
                    chk("mem_op", 128'({mem_read, mem_write}), 128'(cur.is_rd ? 2'b10 : 2'b01));
                    chk("mem_addr", 128'(mem_address), 128'(cur.addr));
                    chk("mem_wdata", 128'(mem_wdata), 128'(cur.wdata));
                    chk("mem_be", 128'(mem_byte_enable), 128'(cur.be));
                end
                cur_sig = {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable};
                in_txn  = 1'b1;
                hi_cnt  = 1;
                lat     = (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
            end
            if (in_txn && strobe && hi_cnt >= lat) begin
                mem_resp  = 1'b1;
                mem_rdata = rdata_of(mem_address);
                in_txn    = 1'b0;
                resp_prev = 1'b1;
            end else if (!strobe) begin
                mem_resp  = force_spur || ($urandom_range(0, 4) == 0);
                mem_rdata = $urandom;
            end else begin
                mem_resp  = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    // Requester side: every completion pulse must match the next expected one.
    logic [DW-1:0] hold = '0;

    always @(negedge clk) begin
        if (rst) begin
            hold = '0;
        end else if (req_resp != '0) begin
            if (exp_resp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req_resp: actual=%0h required 0", req_resp);
            end else begin
                txn_t e;
                e = exp_resp.pop_front();
                chk("resp_channel", 128'(req_resp), 128'(N'(1) << e.ch));
                chk("resp_rdata", 128'(req_rdata), 128'(e.rdata));
                hold = e.rdata;
            end
        end else begin
            chk("rdata_hold", 128'(req_rdata), 128'(hold));
        end
    end

    always @(negedge clk) fp_mem_resp = !rst && (fp_mem_read || fp_mem_write);

    task automatic set_ch(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [BW-1:0] be);
        ch_addr[c]  = a;
        ch_wdata[c] = d;
        ch_be[c]    = be;
    endtask

    // Reference order: requests held until served, so the set is drained by
    // repeatedly picking the first requester at or after the pointer.
    task automatic issue(input logic [N-1:0] rd_m, input logic [N-1:0] wr_m, input int l);
        logic [N-1:0] pend;
        txn_t e;
        bit found;
        pend = rd_m | wr_m;
        while (pend != '0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found) begin
                    int c;
                    c = (model_ptr + k) % N;
                    if (pend[c]) begin
                        e.ch    = c;
                        e.is_rd = rd_m[c];
                        e.addr  = ch_addr[c];
                        e.wdata = ch_wdata[c];
                        e.be    = ch_be[c];
                        e.rdata = e.is_rd ? rdata_of(ch_addr[c]) : model_rdata;
                        model_rdata = e.rdata;
                        exp_mem.push_back(e);
                        exp_resp.push_back(e);
                        pend[c]   = 1'b0;
                        model_ptr = (c + 1) % N;
                        found     = 1'b1;
                    end
                end
            end
        end
        force_lat = l;
        for (int c = 0; c < N; c++) begin
            req_address[c*AW +: AW]     = ch_addr[c];
            req_wdata[c*DW +: DW]       = ch_wdata[c];
            req_byte_enable[c*BW +: BW] = ch_be[c];
        end
        req_read  = rd_m;
        req_write = wr_m;
    endtask

    task automatic wait_done(input bit drop_on_grant);
        bit done;
        done = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) chk("grant_latency", 128'(mem_read | mem_write), 128'(1));
            if (drop_on_grant && (mem_read || mem_write)) begin
                req_read  = '0;
                req_write = '0;
            end
            req_read  = req_read & ~req_resp;
            req_write = req_write & ~req_resp;
            if ((req_read | req_write) == '0 && exp_resp.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL batch_timeout: actual pending=%0d required 0", exp_resp.size());
            req_read  = '0;
            req_write = '0;
        end
    endtask

    task automatic run(input logic [N-1:0] rd_m, input logic [N-1:0] wr_m, input int l,
                       input bit drop_on_grant);
        issue(rd_m, wr_m, l);
        wait_done(drop_on_grant);
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, 128'({mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, req_resp, req_rdata}),
            128'(0));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] mask, rd, wr;
        int pulses, op;
        for (int c = 0; c < N; c++) set_ch(c, '0, '0, '0);
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_outputs");
        rst = 1'b0;
        @(negedge clk);

        set_ch(0, 32'h0000_0040, 32'h0, 4'hF);
        run(4'b0001, 4'b0000, 3, 1'b0);

        set_ch(1, 32'h0000_0100, 32'h1234_5678, 4'b0011);
        run(4'b0000, 4'b0010, 2, 1'b1);

        set_ch(0, 32'h0000_0200, 32'hCAFE_F00D, 4'b1100);
        run(4'b0001, 4'b0001, 1, 1'b0);
        force_spur = 1'b1;
        repeat (4) @(negedge clk);
        force_spur = 1'b0;
        @(negedge clk);

        set_ch(0, 32'h0000_0300, 32'h0, 4'hF);
        set_ch(1, 32'h0000_0304, 32'h0, 4'hF);
        repeat (2) run(4'b0011, 4'b0000, 0, 1'b0);

        set_ch(2, 32'h0000_0400, 32'h0, 4'hF);
        run(4'b0100, 4'b0000, 1, 1'b0);
        set_ch(1, 32'h0000_0500, 32'h0, 4'hF);
        set_ch(3, 32'h0000_0504, 32'h0, 4'hF);
        run(4'b1010, 4'b0000, 0, 1'b0);

        // Leave the pointer at 3, then abandon a long access with a reset.
        run(4'b0100, 4'b0000, 1, 1'b0);
        issue(4'b0001, 4'b0000, 20);
        repeat (3) @(negedge clk);
        rst       = 1'b1;
        req_read  = '0;
        req_write = '0;
        exp_mem.delete();
        exp_resp.delete();
        model_ptr   = 0;
        model_rdata = '0;
        repeat (2) begin
            @(negedge clk);
            chk_reset_outputs("mid_busy_reset_outputs");
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run(4'b1010, 4'b0000, 0, 1'b0);

        for (int b = 0; b < 150; b++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            rd   = '0;
            wr   = '0;
            for (int c = 0; c < N; c++) begin
                if (mask[c]) begin
                    set_ch(c, $urandom, $urandom, BW'($urandom_range(0, (1 << BW) - 1)));
                    op = $urandom_range(0, 9);
                    if (op < 5) rd[c] = 1'b1;
                    else if (op < 9) wr[c] = 1'b1;
                    else begin
                        rd[c] = 1'b1;
                        wr[c] = 1'b1;
                    end
                end
            end
            run(rd, wr, 0, 1'b0);
        end

        fp_req_read = 2'b11;
        pulses = 0;
        repeat (45) begin
            @(negedge clk);
            if (fp_req_resp != '0) begin
                chk("fp_grant", 128'(fp_req_resp), 128'(2'b01));
                pulses++;
            end
        end
        fp_req_read = '0;
        chk("fp_pulse_count", 128'(pulses >= 12), 128'(1));

        repeat (5) @(negedge clk);
        chk("queues_empty", 128'(exp_mem.size() + exp_resp.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
